// File: rtl/irq_concentrator_pkg.sv
// Shared register map and mode encodings for the PL-to-PS interrupt concentrator.
package irq_concentrator_pkg;

    localparam logic [3:0] REG_MASK    = 4'h0;
    localparam logic [3:0] REG_MODE    = 4'h1;
    localparam logic [3:0] REG_PENDING = 4'h2;
    localparam logic [3:0] REG_RAW     = 4'h3;
    localparam logic [3:0] REG_INFO    = 4'h4;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_EDGE  = 1'b1;

    function automatic logic [31:0] info_word(input int irq_num, input int sync_stages);
        return {20'd0, sync_stages[3:0], irq_num[7:0]};
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt source: metastability chain, previous-sample flop and rising-edge detect.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic irq_sync,
    output logic irq_rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], irq_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign irq_sync = sync_q[SYNC_STAGES-1];
    assign irq_rise = irq_sync & ~prev_q;

endmodule

// File: rtl/irq_concentrator.sv
// Interrupt concentrator top: per-source sync, mask/mode/pending registers and the up_* bus.
module irq_concentrator
    import irq_concentrator_pkg::*;
#(
    parameter int IRQ_NUM       = 16,
    parameter int SYNC_STAGES   = 2,
    parameter int IRQ_F2P_WIDTH = 16
) (
    input  logic                     axi_aclk,
    input  logic                     axi_reset,
    input  logic [IRQ_NUM-1:0]       irq_in,
    output logic [IRQ_F2P_WIDTH-1:0] irq_f2p,
    output logic                     irq_any,
    input  logic                     up_wreq,
    input  logic [3:0]               up_waddr,
    input  logic [31:0]              up_wdata,
    output logic                     up_wack,
    input  logic                     up_rreq,
    input  logic [3:0]               up_raddr,
    output logic [31:0]              up_rdata,
    output logic                     up_rack
);

    logic [IRQ_NUM-1:0]       irq_sync, irq_rise;
    logic [IRQ_NUM-1:0]       mask_q, mask_d, mode_q, mode_d, pend_q, pend_d;
    logic [IRQ_NUM-1:0]       wr_bits, w1c, mode_chg, active;
    logic [IRQ_F2P_WIDTH-1:0] irq_f2p_q, irq_f2p_d;
    logic                     irq_any_q, irq_any_d;
    logic                     wack_q, wack_d, rack_q, rack_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     wr_mask, wr_mode, wr_pend;
    logic                     unused_wdata;

    for (genvar gi = 0; gi < IRQ_NUM; gi++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES)
        ) u_sync (
            .clk     (axi_aclk),
            .rst     (axi_reset),
            .irq_in  (irq_in[gi]),
            .irq_sync(irq_sync[gi]),
            .irq_rise(irq_rise[gi])
        );
    end

    assign wr_bits      = up_wdata[IRQ_NUM-1:0];
    assign unused_wdata = ^up_wdata;

    always_comb begin
        wr_mask  = up_wreq && (up_waddr == REG_MASK);
        wr_mode  = up_wreq && (up_waddr == REG_MODE);
        wr_pend  = up_wreq && (up_waddr == REG_PENDING);
        mask_d   = wr_mask ? wr_bits : mask_q;
        mode_d   = wr_mode ? wr_bits : mode_q;
        mode_chg = wr_mode ? (wr_bits ^ mode_q) : '0;
        w1c      = wr_pend ? wr_bits : '0;

        // Edge bits: a fresh rise wins over a same-cycle W1C so no event is lost.
        pend_d = '0;
        for (int i = 0; i < IRQ_NUM; i++) begin
            if (mode_q[i] == MODE_EDGE)
                pend_d[i] = irq_rise[i] | (pend_q[i] & ~w1c[i]);
            else
                pend_d[i] = irq_sync[i];
        end
        pend_d = pend_d & ~mode_chg;

        active    = pend_q & mask_q;
        irq_f2p_d = IRQ_F2P_WIDTH'(active);
        irq_any_d = |active;
        wack_d    = up_wreq;
        rack_d    = up_rreq;

        rdata_d = '0;
        if (up_rreq) begin
            case (up_raddr)
                REG_MASK:    rdata_d = 32'(mask_q);
                REG_MODE:    rdata_d = 32'(mode_q);
                REG_PENDING: rdata_d = 32'(pend_q);
                REG_RAW:     rdata_d = 32'(irq_sync);
                REG_INFO:    rdata_d = info_word(IRQ_NUM, SYNC_STAGES);
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_reset) begin
            mask_q    <= '0;
            mode_q    <= '0;
            pend_q    <= '0;
            irq_f2p_q <= '0;
            irq_any_q <= 1'b0;
            wack_q    <= 1'b0;
            rack_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            mask_q    <= mask_d;
            mode_q    <= mode_d;
            pend_q    <= pend_d;
            irq_f2p_q <= irq_f2p_d;
            irq_any_q <= irq_any_d;
            wack_q    <= wack_d;
            rack_q    <= rack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign irq_f2p  = irq_f2p_q;
    assign irq_any  = irq_any_q;
    assign up_wack  = wack_q;
    assign up_rack  = rack_q;
    assign up_rdata = rdata_q;

endmodule
